// File: rtl/pcn_array_conv_if.sv
// Handshake/data bundle between the decoder top level and the parity-check array.
// The master drives sample control and check-node inputs; the slave returns results.
interface pcn_array_conv_if #(
    parameter int NCH  = 4,
    parameter int DEG  = 6,
    parameter int CYCW = 16,
    parameter int CW   = $clog2(NCH + 1)
);
    logic                en;
    logic                clr;
    logic [NCH*DEG-1:0]  q;
    logic [NCH*DEG-1:0]  r;
    logic [NCH-1:0]      sat;
    logic                all_sat;
    logic [CW-1:0]       unsat_cnt;
    logic [CYCW-1:0]     cyc_cnt;
    logic                busy;
    logic                converged;
    logic                timeout;

    modport master (
        output en, clr, q,
        input  r, sat, all_sat, unsat_cnt, cyc_cnt, busy, converged, timeout
    );

    modport slave (
        input  en, clr, q,
        output r, sat, all_sat, unsat_cnt, cyc_cnt, busy, converged, timeout
    );
endinterface

// File: rtl/pcn_array_conv.sv
// NCH parallel stochastic parity-check nodes with registered extrinsic outputs,
// plus per-frame convergence tracking and a decode-cycle timeout.
module pcn_array_conv #(
    parameter int NCH      = 4,
    parameter int DEG      = 6,
    parameter int CONV_LEN = 16,
    parameter int MAX_CYC  = 1000,
    parameter int CYCW     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    pcn_array_conv_if.slave     bus
);
    localparam int CW = $clog2(NCH + 1);
    localparam int RW = $clog2(CONV_LEN + 1);

    typedef enum logic [1:0] {IDLE, RUN, CONV, TMO} state_t;

    state_t              state, state_next;
    logic [NCH*DEG-1:0]  r_q, r_next;
    logic [NCH-1:0]      sat_q, p;
    logic                all_sat_q, all_sat_c;
    logic [CW-1:0]       unsat_q, unsat_c;
    logic [CYCW-1:0]     cyc_q, cyc_next;
    logic [RW-1:0]       run_q, run_next;
    logic                count_en;

    // NOTE: every variable written here gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        p         = '0;
        r_next    = '0;
        unsat_c   = '0;
        for (int c = 0; c < NCH; c++) begin
            p[c] = ^bus.q[c*DEG +: DEG];
            // XOR with the channel parity leaves the XOR of the other DEG-1 inputs.
            r_next[c*DEG +: DEG] = bus.q[c*DEG +: DEG] ^ {DEG{p[c]}};
            unsat_c = unsat_c + CW'(p[c]);
        end
        all_sat_c = ~|p;
    end

    assign count_en = bus.en && !bus.clr && (state == IDLE || state == RUN);
    assign cyc_next = cyc_q + CYCW'(1);
    assign run_next = all_sat_c ? run_q + RW'(1) : '0;

    always_comb begin
        state_next = state;
        if (bus.clr) begin
            state_next = IDLE;
        end else if (count_en) begin
            // Convergence takes precedence when both limits are reached together.
            if (run_next == RW'(CONV_LEN))
                state_next = CONV;
            else if (cyc_next == CYCW'(MAX_CYC))
                state_next = TMO;
            else
                state_next = RUN;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cyc_q <= '0;
            run_q <= '0;
        end else begin
            state <= state_next;
            if (bus.clr) begin
                cyc_q <= '0;
                run_q <= '0;
            end else if (count_en) begin
                cyc_q <= cyc_next;
                run_q <= run_next;
            end
        end
    end

    // The datapath keeps tracking Q in every state, including the sticky ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= '0;
            sat_q     <= '0;
            all_sat_q <= 1'b0;
            unsat_q   <= '0;
        end else if (bus.clr) begin
            r_q       <= '0;
            sat_q     <= '0;
            all_sat_q <= 1'b0;
            unsat_q   <= '0;
        end else if (bus.en) begin
            r_q       <= r_next;
            sat_q     <= ~p;
            all_sat_q <= all_sat_c;
            unsat_q   <= unsat_c;
        end
    end

    assign bus.r         = r_q;
    assign bus.sat       = sat_q;
    assign bus.all_sat   = all_sat_q;
    assign bus.unsat_cnt = unsat_q;
    assign bus.cyc_cnt   = cyc_q;
    assign bus.busy      = (state == RUN);
    assign bus.converged = (state == CONV);
    assign bus.timeout   = (state == TMO);
endmodule

// File: doc/pcn_array_conv.md
# pcn_array_conv

Parametrised, multi-channel successor to the single stochastic parity-check node. It evaluates NCH parity checks of degree DEG in parallel and returns registered extrinsic bits to the variable nodes. It also tracks per-frame convergence, counting consecutive all-checks-satisfied cycles, and provides a decode-cycle timeout so the stochastic LDPC decoder top level can stop early.

## Interface
- NCH, 4: number of parity checks (channels), ≥1
- DEG, 6: check-node degree (inputs per channel), ≥2
- CONV_LEN, 16: consecutive all-satisfied sampled cycles required to declare convergence, ≥1
- MAX_CYC, 1000: sampled decode cycles per frame before timeout, ≥1
- CYCW, 16: width of CYC_CNT, with MAX_CYC ≤ 2^CYCW−1
- CW, $clog2(NCH+1): width of UNSAT_CNT

- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- EN  in  1  sample Q and advance the block this cycle
- CLR  in  1  synchronous frame clear; has priority over EN
- Q  in  NCH*DEG  input stochastic bits; channel c occupies Q[c*DEG +: DEG]
- R  out  NCH*DEG  registered output bits, same packing as Q
- SAT  out  NCH  registered; SAT[c]=1 when channel c had even parity
- ALL_SAT  out  1  registered AND of all SAT bits
- UNSAT_CNT  out  CW  registered count of channels with odd parity
- CYC_CNT  out  CYCW  sampled cycles since the last CLR or reset
- BUSY  out  1  state is RUN
- CONVERGED  out  1  sticky; state is CONV
- TIMEOUT  out  1  sticky; state is TMO

## Operation
- Per channel, parity p[c] = XOR of the channel's DEG bits. The next R bit for input l is Q[l] XOR p[c], which equals the XOR of the other DEG−1 inputs. The next SAT[c] is ~p[c].
- all_sat_c is the combinational AND of ~p[c] over all channels. unsat_c is the combinational popcount of p.
- Datapath registers (R, SAT, ALL_SAT, UNSAT_CNT) load on every EN cycle in every state. When EN=0 they hold.
- FSM states:
  - IDLE: reset state. On EN, go to RUN; this first sample counts.
  - RUN: evaluate each EN cycle.
  - CONV: sticky.
  - TMO: sticky.
- Counting on each EN cycle in IDLE or RUN:
  - cyc_next = CYC_CNT+1.
  - run_next = all_sat_c ? run+1 : 0. The run counter width is $clog2(CONV_LEN+1).
- Transitions evaluated on the same edge:
  - If run_next == CONV_LEN, go to CONV.
  - Otherwise, if cyc_next == MAX_CYC, go to TMO.
  - Otherwise, go to RUN.
  - If both conditions hold on the same edge, CONV wins.
- In CONV and TMO, CYC_CNT and the run counter freeze. The datapath keeps tracking Q.
- EN=0 in RUN: counters hold. The run counter is not reset by gaps.
- CLR=1 (any state, with or without EN): all registers and counters go to 0 and the state goes to IDLE. Q is not sampled on that cycle.
- CYC_CNT never exceeds MAX_CYC, so it never wraps.

## Timing
- Reset (RST_N low, asynchronous): every output is 0, state is IDLE, and the run counter is 0. Release is synchronous to the next CLK edge.
- Latency: Q sampled at edge k appears on R, SAT, ALL_SAT, and UNSAT_CNT after edge k. That is 1 cycle.
- CYC_CNT, BUSY, CONVERGED, and TIMEOUT update on the same edge as the datapath sample that caused the change.
- CONVERGED rises on the edge that samples the CONV_LEN-th consecutive satisfied EN cycle. ALL_SAT is 1 in that same cycle.
- TIMEOUT rises on the edge that samples the MAX_CYC-th EN cycle, unless convergence occurs on that same edge.
- RST_N asserted mid-frame aborts immediately: outputs go to 0 with no waiting for a clock.

## Test plan
All scenarios use NCH=4, DEG=6, CONV_LEN=3, MAX_CYC=10.
- Reset: assert RST_N=0 mid-RUN with no clock edge. All outputs read 0 immediately, and BUSY=0.
- Extrinsic bits: drive channel 0 Q=6'b000111, other channels 0, EN=1. After one edge: R[5:0]=6'b111000, SAT=4'b1110, ALL_SAT=0, UNSAT_CNT=1, CYC_CNT=1, BUSY=1.
- Convergence: drive Q=0 for 3 EN cycles. CONVERGED=1 after the 3rd edge and CYC_CNT=3. Apply 5 more cycles with odd Q: CONVERGED stays 1, CYC_CNT stays 3, R keeps tracking Q.
- Timeout and gaps: drive channel 2 with odd parity continuously. Insert EN=0 for 4 cycles after the 5th sample, and check CYC_CNT holds at 5. TIMEOUT=1 after the 10th sample and CYC_CNT=10. Also drive 2 satisfied samples, then 1 EN=0 gap, then 1 satisfied sample: CONVERGED=1, confirming the run counter is not reset by the gap.
- Simultaneous conditions: arrange 7 unsatisfied samples followed by 3 satisfied samples, so the 10th sample completes the run. Expect CONVERGED=1 and TIMEOUT=0.
- Clear priority: assert CLR=1 together with EN=1 and odd Q in state CONV. Next cycle: every output is 0 and BUSY=0. The following EN cycle sets BUSY=1 and CYC_CNT=1.
